// File: rtl/lh_ingress_buf_pkg.sv
// Shared types and default sizes for the lh ingress packet-commit buffer.
package lh_ingress_buf_pkg;

  localparam int DATA_NBITS               = 32;
  localparam int LH_IBUF_DEPTH_NBITS      = 6;
  localparam int LH_IBUF_META_DEPTH_NBITS = 4;
  localparam int LH_IBUF_CNT_NBITS        = 16;

  typedef struct packed {
    logic [3:0]  port;
    logic [11:0] tag;
    logic        discard;
  } irl_lh_meta_type;

  typedef enum logic [1:0] {IDLE, ACCEPT, DROP} lh_ibuf_state_e;

endpackage

// File: rtl/lh_ibuf_out_stage.sv
// Valid/ready output stage: the upstream registered RAM read acts as the output
// register, and a single hold register catches it when downstream stalls.
module lh_ibuf_out_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  logic             hold_valid_reg;
  logic [WIDTH-1:0] hold_data_reg;

  // The input slot is released when it is consumed or parked in the hold register.
  assign in_ready  = !hold_valid_reg || out_ready;
  assign out_valid = hold_valid_reg || in_valid;
  assign out_data  = hold_valid_reg ? hold_data_reg : (in_valid ? in_data : '0);

  always_ff @(posedge clk) begin
    if (srst) begin
      hold_valid_reg <= 1'b0;
      hold_data_reg  <= '0;
    end else if (hold_valid_reg) begin
      if (out_ready) begin
        hold_valid_reg <= in_valid;
        hold_data_reg  <= in_data;
      end
    end else if (in_valid && !out_ready) begin
      hold_valid_reg <= 1'b1;
      hold_data_reg  <= in_data;
    end
  end

endmodule

// File: rtl/lh_ingress_buf.sv
// Packet-commit ingress buffer: beats are written tentatively and only become
// readable once the eop beat commits; discarded/malformed/overflowing packets are dropped whole.
module lh_ingress_buf
  import lh_ingress_buf_pkg::*;
#(
  parameter int DEPTH_NBITS      = LH_IBUF_DEPTH_NBITS,
  parameter int META_DEPTH_NBITS = LH_IBUF_META_DEPTH_NBITS,
  parameter int CNT_NBITS        = LH_IBUF_CNT_NBITS
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  irl_lh_valid,
  input  logic [DATA_NBITS-1:0] irl_lh_hdr_data,
  input  irl_lh_meta_type       irl_lh_meta_data,
  input  logic                  irl_lh_sop,
  input  logic                  irl_lh_eop,
  output logic                  lh_valid,
  input  logic                  lh_ready,
  output logic [DATA_NBITS-1:0] lh_hdr_data,
  output irl_lh_meta_type       lh_meta_data,
  output logic                  lh_sop,
  output logic                  lh_eop,
  output logic [CNT_NBITS-1:0]  drop_discard_cnt,
  output logic [CNT_NBITS-1:0]  drop_ovf_cnt,
  output logic [CNT_NBITS-1:0]  err_cnt
);

  localparam int PW   = DEPTH_NBITS + 1;
  localparam int MPW  = META_DEPTH_NBITS + 1;
  localparam int WORD = DATA_NBITS + 2;
  localparam logic [PW-1:0]        PTR_ONE   = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]        DATA_CAP  = {1'b1, {DEPTH_NBITS{1'b0}}};
  localparam logic [MPW-1:0]       MPTR_ONE  = {{(MPW-1){1'b0}}, 1'b1};
  localparam logic [MPW-1:0]       META_CAP  = {1'b1, {META_DEPTH_NBITS{1'b0}}};
  localparam logic [CNT_NBITS-1:0] CNT_ONE   = {{(CNT_NBITS-1){1'b0}}, 1'b1};

  lh_ibuf_state_e  state_reg, state_next;
  logic [PW-1:0]   wptr_tent_reg, wptr_tent_next, wptr_com_reg, wptr_com_next, rptr_reg;
  logic [MPW-1:0]  meta_wptr_reg, meta_rptr_reg;
  irl_lh_meta_type meta_stage_reg, meta_stage_next, meta_push_data;
  logic            wr_en, meta_push, discard_inc, ovf_inc, err_inc;
  logic [DEPTH_NBITS-1:0] wr_addr;

  logic [WORD-1:0] mem [2**DEPTH_NBITS];
  logic [WORD-1:0] mem_rd_reg;
  irl_lh_meta_type meta_mem [2**META_DEPTH_NBITS];
  logic            rd_valid_reg, rd_issue, stage_in_ready;
  logic [WORD-1:0] stage_out_data;

  wire meta_full = (meta_wptr_reg - meta_rptr_reg) == META_CAP;
  wire com_full  = (wptr_com_reg - rptr_reg) == DATA_CAP;
  wire tent_full = (wptr_tent_reg - rptr_reg) == DATA_CAP;

  always_comb begin
    state_next      = state_reg;
    wptr_tent_next  = wptr_tent_reg;
    wptr_com_next   = wptr_com_reg;
    meta_stage_next = meta_stage_reg;
    meta_push_data  = meta_stage_reg;
    wr_en           = 1'b0;
    wr_addr         = wptr_tent_reg[DEPTH_NBITS-1:0];
    meta_push       = 1'b0;
    discard_inc     = 1'b0;
    ovf_inc         = 1'b0;
    err_inc         = 1'b0;
    if (irl_lh_valid && irl_lh_sop) begin
      // A sop always restarts from the committed pointer, abandoning any partial packet.
      err_inc        = (state_reg != IDLE);
      wptr_tent_next = wptr_com_reg;
      if (irl_lh_meta_data.discard) begin
        discard_inc = 1'b1;
        state_next  = irl_lh_eop ? IDLE : DROP;
      end else if (meta_full || com_full) begin
        ovf_inc    = 1'b1;
        state_next = irl_lh_eop ? IDLE : DROP;
      end else begin
        wr_en           = 1'b1;
        wr_addr         = wptr_com_reg[DEPTH_NBITS-1:0];
        wptr_tent_next  = wptr_com_reg + PTR_ONE;
        meta_stage_next = irl_lh_meta_data;
        meta_push_data  = irl_lh_meta_data;
        if (irl_lh_eop) begin
          wptr_com_next = wptr_com_reg + PTR_ONE;
          meta_push     = 1'b1;
          state_next    = IDLE;
        end else begin
          state_next = ACCEPT;
        end
      end
    end else if (irl_lh_valid) begin
      case (state_reg)
        IDLE: err_inc = 1'b1;
        ACCEPT: begin
          if (tent_full) begin
            wptr_tent_next = wptr_com_reg;
            ovf_inc        = 1'b1;
            state_next     = irl_lh_eop ? IDLE : DROP;
          end else begin
            wr_en          = 1'b1;
            wptr_tent_next = wptr_tent_reg + PTR_ONE;
            if (irl_lh_eop) begin
              wptr_com_next = wptr_tent_reg + PTR_ONE;
              meta_push     = 1'b1;
              state_next    = IDLE;
            end
          end
        end
        DROP:    if (irl_lh_eop) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg        <= IDLE;
      wptr_tent_reg    <= '0;
      wptr_com_reg     <= '0;
      rptr_reg         <= '0;
      meta_wptr_reg    <= '0;
      meta_rptr_reg    <= '0;
      meta_stage_reg   <= '0;
      rd_valid_reg     <= 1'b0;
      drop_discard_cnt <= '0;
      drop_ovf_cnt     <= '0;
      err_cnt          <= '0;
    end else begin
      state_reg      <= state_next;
      wptr_tent_reg  <= wptr_tent_next;
      wptr_com_reg   <= wptr_com_next;
      meta_stage_reg <= meta_stage_next;
      rd_valid_reg   <= rd_issue || (rd_valid_reg && !stage_in_ready);
      if (rd_issue) rptr_reg <= rptr_reg + PTR_ONE;
      if (meta_push) meta_wptr_reg <= meta_wptr_reg + MPTR_ONE;
      if (lh_valid && lh_ready && lh_eop) meta_rptr_reg <= meta_rptr_reg + MPTR_ONE;
      if (discard_inc && drop_discard_cnt != '1) drop_discard_cnt <= drop_discard_cnt + CNT_ONE;
      if (ovf_inc && drop_ovf_cnt != '1) drop_ovf_cnt <= drop_ovf_cnt + CNT_ONE;
      if (err_inc && err_cnt != '1) err_cnt <= err_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= {irl_lh_sop, irl_lh_eop, irl_lh_hdr_data};
    if (rd_issue) mem_rd_reg <= mem[rptr_reg[DEPTH_NBITS-1:0]];
    if (meta_push) meta_mem[meta_wptr_reg[META_DEPTH_NBITS-1:0]] <= meta_push_data;
  end

  // Only committed entries are read, so a read never races the write of the same slot.
  assign rd_issue = (rptr_reg != wptr_com_reg) && (!rd_valid_reg || stage_in_ready);

  lh_ibuf_out_stage #(.WIDTH(WORD)) u_out_stage (
    .clk       (clk),
    .srst      (srst),
    .in_valid  (rd_valid_reg),
    .in_data   (mem_rd_reg),
    .in_ready  (stage_in_ready),
    .out_valid (lh_valid),
    .out_data  (stage_out_data),
    .out_ready (lh_ready)
  );

  assign {lh_sop, lh_eop, lh_hdr_data} = stage_out_data;
  assign lh_meta_data = lh_valid ? meta_mem[meta_rptr_reg[META_DEPTH_NBITS-1:0]] : '0;

endmodule

// File: tb/tb_lh_ingress_buf.sv
// Scoreboard bench for lh_ingress_buf: expected beats are queued as packets are driven
// and compared beat-by-beat as they leave the buffer.
module tb_lh_ingress_buf;
  import lh_ingress_buf_pkg::*;

  typedef struct packed {
    logic            sop;
    logic            eop;
    logic [31:0]     data;
    irl_lh_meta_type meta;
  } exp_t;

  logic clk = 1'b0, srst = 1'b0;
  logic irl_lh_valid = 1'b0, irl_lh_sop = 1'b0, irl_lh_eop = 1'b0;
  logic [DATA_NBITS-1:0] irl_lh_hdr_data = '0;
  irl_lh_meta_type irl_lh_meta_data = '0;
  logic lh_valid, lh_ready = 1'b0, lh_sop, lh_eop;
  logic [DATA_NBITS-1:0] lh_hdr_data;
  irl_lh_meta_type lh_meta_data;
  logic [15:0] drop_discard_cnt, drop_ovf_cnt, err_cnt;

  exp_t exp_q[$];
  int total = 0, bad = 0, out_cnt = 0, cyc = 0;
  int first_valid_cyc = -1, last_eop_cyc = 0;

  lh_ingress_buf dut (
    .clk(clk), .srst(srst),
    .irl_lh_valid(irl_lh_valid), .irl_lh_hdr_data(irl_lh_hdr_data),
    .irl_lh_meta_data(irl_lh_meta_data), .irl_lh_sop(irl_lh_sop), .irl_lh_eop(irl_lh_eop),
    .lh_valid(lh_valid), .lh_ready(lh_ready), .lh_hdr_data(lh_hdr_data),
    .lh_meta_data(lh_meta_data), .lh_sop(lh_sop), .lh_eop(lh_eop),
    .drop_discard_cnt(drop_discard_cnt), .drop_ovf_cnt(drop_ovf_cnt), .err_cnt(err_cnt)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // Output monitor: every transferred beat must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!srst && lh_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (lh_ready) begin
          total++;
          out_cnt++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL beat_unexpected got sop=%0b eop=%0b data=%h, required none", lh_sop, lh_eop, lh_hdr_data);
          end else begin
            e = exp_q.pop_front();
            if ({lh_sop, lh_eop, lh_hdr_data, lh_meta_data} !== e) begin
              bad++;
              $display("FAIL beat got sop=%0b eop=%0b data=%h meta=%h, required sop=%0b eop=%0b data=%h meta=%h",
                       lh_sop, lh_eop, lh_hdr_data, lh_meta_data, e.sop, e.eop, e.data, e.meta);
            end else begin
              $display("beat out sop=%0b eop=%0b data=%h meta=%h", lh_sop, lh_eop, lh_hdr_data, lh_meta_data);
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  function automatic irl_lh_meta_type mk_meta(input logic [3:0] port, input logic [11:0] tag, input logic discard);
    irl_lh_meta_type m;
    m.port = port; m.tag = tag; m.discard = discard;
    return m;
  endfunction

  task automatic send_beat(input logic sop, input logic eop, input logic [31:0] data, input irl_lh_meta_type meta);
    irl_lh_valid = 1'b1; irl_lh_sop = sop; irl_lh_eop = eop;
    irl_lh_hdr_data = data; irl_lh_meta_data = meta;
    if (eop) last_eop_cyc = cyc;
    @(posedge clk); #1;
    irl_lh_valid = 1'b0; irl_lh_sop = 1'b0; irl_lh_eop = 1'b0;
  endtask

  task automatic send_pkt(input int n, input logic [31:0] base, input irl_lh_meta_type meta, input bit keep);
    for (int i = 0; i < n; i++) begin
      if (keep) exp_q.push_back({1'(i == 0), 1'(i == n - 1), base + 32'(i), meta});
      send_beat(i == 0, i == n - 1, base + 32'(i), meta);
    end
  endtask

  task automatic do_reset();
    srst = 1'b1;
    repeat (2) @(posedge clk);
    #1 srst = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (exp_q.size() != 0 || lh_valid !== 1'b0) begin
      bad++;
      $display("FAIL drain got pending=%0d lh_valid=%0b, required pending=0 lh_valid=0", exp_q.size(), lh_valid);
    end
  endtask

  task automatic test_reset();
    srst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({lh_valid, lh_sop, lh_eop} !== 3'b000 || lh_hdr_data !== '0 || lh_meta_data !== '0) begin
      bad++;
      $display("FAIL reset_outputs got v/s/e=%b data=%h meta=%h, required 000/0/0", {lh_valid, lh_sop, lh_eop}, lh_hdr_data, lh_meta_data);
    end
    total++;
    if ({drop_discard_cnt, drop_ovf_cnt, err_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_counters got %h/%h/%h, required 0/0/0", drop_discard_cnt, drop_ovf_cnt, err_cnt);
    end
    @(posedge clk); #1 srst = 1'b0;
  endtask

  task automatic test_back_to_back();
    int eop1_cyc;
    do_reset();
    lh_ready = 1'b1;
    first_valid_cyc = -1;
    send_pkt(4, 32'h1, mk_meta(4'h1, 12'h111, 1'b0), 1'b1);
    eop1_cyc = last_eop_cyc;
    send_pkt(4, 32'h5, mk_meta(4'h2, 12'h222, 1'b0), 1'b1);
    send_pkt(4, 32'h9, mk_meta(4'h3, 12'h333, 1'b0), 1'b1);
    wait_drain(100);
    total++;
    if (first_valid_cyc !== eop1_cyc + 2) begin
      bad++;
      $display("FAIL b2b_latency got cycle %0d, required %0d", first_valid_cyc, eop1_cyc + 2);
    end
    total++;
    if ({drop_discard_cnt, drop_ovf_cnt, err_cnt} !== '0) begin
      bad++;
      $display("FAIL b2b_counters got %h/%h/%h, required 0/0/0", drop_discard_cnt, drop_ovf_cnt, err_cnt);
    end
  endtask

  task automatic test_discard();
    do_reset();
    lh_ready = 1'b1;
    send_pkt(2, 32'hA0, mk_meta(4'hA, 12'hAAA, 1'b0), 1'b1);
    send_pkt(3, 32'hB0, mk_meta(4'hB, 12'hBBB, 1'b1), 1'b0);
    send_pkt(1, 32'hC0, mk_meta(4'hC, 12'hCCC, 1'b0), 1'b1);
    wait_drain(100);
    total++;
    if (drop_discard_cnt !== 16'd1 || drop_ovf_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      bad++;
      $display("FAIL discard_counters got %0d/%0d/%0d, required 1/0/0", drop_discard_cnt, drop_ovf_cnt, err_cnt);
    end
  endtask

  task automatic test_overflow();
    int base_cnt;
    do_reset();
    lh_ready = 1'b0;
    send_pkt(64, 32'h100, mk_meta(4'h4, 12'h404, 1'b0), 1'b1);
    send_pkt(2, 32'h200, mk_meta(4'h5, 12'h505, 1'b0), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (drop_ovf_cnt !== 16'd1) begin
      bad++;
      $display("FAIL ovf_count got %0d, required 1", drop_ovf_cnt);
    end
    total++;
    if (lh_valid !== 1'b1 || lh_sop !== 1'b1 || lh_hdr_data !== 32'h100) begin
      bad++;
      $display("FAIL ovf_stall_head got v=%0b sop=%0b data=%h, required 1/1/00000100", lh_valid, lh_sop, lh_hdr_data);
    end
    base_cnt = out_cnt;
    lh_ready = 1'b1;
    wait_drain(300);
    total++;
    if (out_cnt - base_cnt !== 64) begin
      bad++;
      $display("FAIL ovf_beats got %0d, required 64", out_cnt - base_cnt);
    end
  endtask

  task automatic test_meta_full();
    int base_cnt;
    do_reset();
    lh_ready = 1'b0;
    for (int i = 0; i < 17; i++)
      send_pkt(1, 32'h300 + 32'(i), mk_meta(4'h6, 12'(i), 1'b0), i < 16);
    total++;
    if (drop_ovf_cnt !== 16'd1) begin
      bad++;
      $display("FAIL meta_full_ovf got %0d, required 1", drop_ovf_cnt);
    end
    base_cnt = out_cnt;
    lh_ready = 1'b1;
    wait_drain(200);
    total++;
    if (out_cnt - base_cnt !== 16) begin
      bad++;
      $display("FAIL meta_full_beats got %0d, required 16", out_cnt - base_cnt);
    end
  endtask

  task automatic test_protocol();
    irl_lh_meta_type m1, m2;
    do_reset();
    lh_ready = 1'b1;
    m1 = mk_meta(4'h7, 12'h701, 1'b0);
    m2 = mk_meta(4'h8, 12'h802, 1'b0);
    send_beat(1'b0, 1'b0, 32'h20, m1);
    send_beat(1'b1, 1'b0, 32'h21, m1);
    exp_q.push_back({1'b1, 1'b0, 32'h22, m2});
    send_beat(1'b1, 1'b0, 32'h22, m2);
    exp_q.push_back({1'b0, 1'b1, 32'h23, m2});
    send_beat(1'b0, 1'b1, 32'h23, m1);
    wait_drain(100);
    total++;
    if (err_cnt !== 16'd2 || drop_ovf_cnt !== 16'd0 || drop_discard_cnt !== 16'd0) begin
      bad++;
      $display("FAIL proto_counters got err=%0d ovf=%0d disc=%0d, required 2/0/0", err_cnt, drop_ovf_cnt, drop_discard_cnt);
    end
  endtask

  // Runs straight after test_protocol so the counters are non-zero going into the reset.
  task automatic test_reset_mid();
    irl_lh_meta_type m;
    m = mk_meta(4'h9, 12'h909, 1'b0);
    lh_ready = 1'b1;
    send_beat(1'b1, 1'b0, 32'h40, m);
    send_beat(1'b0, 1'b0, 32'h41, m);
    srst = 1'b1;
    @(posedge clk); #1 srst = 1'b0;
    total++;
    if (lh_valid !== 1'b0 || {drop_discard_cnt, drop_ovf_cnt, err_cnt} !== '0) begin
      bad++;
      $display("FAIL midreset_state got v=%0b cnt=%h/%h/%h, required 0 and 0/0/0", lh_valid, drop_discard_cnt, drop_ovf_cnt, err_cnt);
    end
    send_beat(1'b0, 1'b0, 32'h42, m);
    total++;
    if (err_cnt !== 16'd1) begin
      bad++;
      $display("FAIL midreset_orphan1 got err=%0d, required 1", err_cnt);
    end
    send_beat(1'b0, 1'b1, 32'h43, m);
    total++;
    if (err_cnt !== 16'd2) begin
      bad++;
      $display("FAIL midreset_orphan2 got err=%0d, required 2", err_cnt);
    end
    send_pkt(1, 32'h50, mk_meta(4'hA, 12'hA0A, 1'b0), 1'b1);
    wait_drain(100);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_discard();
    test_overflow();
    test_meta_full();
    test_protocol();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
